// File: rtl/prgn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prgn_pkg
// Brief    : Shared types, shift constants and the xorshift32 step function
//            for the PRGN xorshift stage.
// Revision : 1.0 - initial release
// ============================================================================
package prgn_pkg;

    localparam int unsigned SH_A = 13;
    localparam int unsigned SH_B = 17;
    localparam int unsigned SH_C = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        GEN  = 1'b1
    } prgn_state_t;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] v;
        v = x ^ (x << SH_A);
        v = v ^ (v >> SH_B);
        v = v ^ (v << SH_C);
        return v;
    endfunction

endpackage : prgn_pkg
`default_nettype wire

// File: rtl/prgn_xorshift_step.sv
`default_nettype none
// ============================================================================
// Module   : prgn_xorshift_step
// Brief    : Purely combinational single xorshift32 step.
// Revision : 1.0 - initial release
// ============================================================================
module prgn_xorshift_step
    import prgn_pkg::*;
(
    input  logic [31:0] i_x,
    output logic [31:0] o_x
);

    assign o_x = xorshift32(i_x);

endmodule : prgn_xorshift_step
`default_nettype wire

// File: rtl/prgn_xorshift_core.sv
`default_nettype none
// ============================================================================
// Module   : prgn_xorshift_core
// Brief    : Seed-in, NUM_OUT-words-out xorshift32 generator on a
//            valid/ready stream with a one-cycle done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module prgn_xorshift_core
    import prgn_pkg::*;
#(
    parameter int unsigned NUM_OUT  = 256,
    parameter logic [31:0] ZERO_SUB = 32'h1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    output logic        seed_ready,
    input  logic [31:0] seed,
    output logic        rand_valid,
    input  logic        rand_ready,
    output logic [31:0] rand_num,
    output logic        busy,
    output logic        done
);

    localparam int unsigned         c_cnt_w = (NUM_OUT > 2) ? $clog2(NUM_OUT) : 1;
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(NUM_OUT - 1);

    prgn_state_t        r_state;
    prgn_state_t        w_state_nxt;
    logic [31:0]        r_s;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_done;

    logic               w_load;
    logic               w_cnt_clr;
    logic               w_cnt_inc;
    logic               w_done_nxt;
    logic [31:0]        w_step_in;
    logic [31:0]        w_step_out;

    // Zero is a fixed point of xorshift, so it is replaced before the first step.
    assign w_step_in = (r_state == IDLE) ? ((seed == 32'h0) ? ZERO_SUB : seed) : r_s;

    prgn_xorshift_step u_step (
        .i_x (w_step_in),
        .o_x (w_step_out)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (seed_valid) begin
                    w_state_nxt = GEN;
                    w_load      = 1'b1;
                    w_cnt_clr   = 1'b1;
                end
            end
            GEN: begin
                if (rand_ready) begin
                    if (r_cnt == c_last) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_load    = 1'b1;
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= 32'h0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            if (w_load) begin
                r_s <= w_step_out;
            end
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // All stream outputs come straight from registers; rand_num holds in IDLE.
    assign seed_ready = (r_state == IDLE);
    assign busy       = (r_state == GEN);
    assign rand_valid = (r_state == GEN);
    assign rand_num   = r_s;
    assign done       = r_done;

endmodule : prgn_xorshift_core
`default_nettype wire

// File: tb/tb_prgn_xorshift_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_prgn_xorshift_core
// Brief    : Randomized self-checking bench for prgn_xorshift_core against an
//            arithmetic reference of the xorshift32 sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prgn_xorshift_core;

    localparam int unsigned NUM_OUT = 256;
    localparam int unsigned LIMIT   = NUM_OUT * 30;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_valid;
    logic        seed_ready;
    logic [31:0] seed;
    logic        rand_valid;
    logic        rand_ready;
    logic [31:0] rand_num;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prgn_xorshift_core #(
        .NUM_OUT  (NUM_OUT),
        .ZERO_SUB (32'h1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed       (seed),
        .rand_valid (rand_valid),
        .rand_ready (rand_ready),
        .rand_num   (rand_num),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Shifts expressed as power-of-two multiply/divide, truncated to 32 bits.
    function automatic logic [31:0] ref_xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x * 32'd8192);
        y = y ^ (y / 32'd131072);
        y = y ^ (y * 32'd32);
        return y;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] s, input int n);
        logic [31:0] x;
        x = (s == 32'h0) ? 32'h1 : s;
        for (int i = 0; i <= n; i++) x = ref_xs(x);
        return x;
    endfunction

    // Offers a seed at a falling edge and consumes the whole sequence.
    task automatic run_seq(input logic [31:0] s, input int ready_pct,
                           input bit hold_valid, input bit stall_last);
        logic [31:0] exp_q[$];
        logic [31:0] x;
        int idx;
        int guard;
        int stalls;
        bit rdy;
        x = (s == 32'h0) ? 32'h1 : s;
        for (int i = 0; i < NUM_OUT; i++) begin
            x = ref_xs(x);
            exp_q.push_back(x);
        end
        check("seed_ready_idle", {31'h0, seed_ready}, 32'h1);
        seed       = s;
        seed_valid = 1'b1;
        rand_ready = 1'b0;
        @(negedge clk);
        if (!hold_valid) seed_valid = 1'b0;
        idx    = 0;
        guard  = 0;
        stalls = 0;
        while (idx < NUM_OUT && guard < LIMIT) begin
            check("rand_valid", {31'h0, rand_valid}, 32'h1);
            check("busy", {31'h0, busy}, 32'h1);
            check("seed_ready_gen", {31'h0, seed_ready}, 32'h0);
            check("done_early", {31'h0, done}, 32'h0);
            check("rand_num", rand_num, exp_q[idx]);
            rdy = ($urandom_range(99) < ready_pct);
            if (stall_last && idx == NUM_OUT - 1 && stalls < 50) begin
                rdy = 1'b0;
                stalls++;
            end
            rand_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            guard++;
        end
        rand_ready = 1'b0;
        check("word_count", idx, NUM_OUT);
        check("done_pulse", {31'h0, done}, 32'h1);
        check("valid_after", {31'h0, rand_valid}, 32'h0);
        check("busy_after", {31'h0, busy}, 32'h0);
        check("num_retained", rand_num, exp_q[NUM_OUT-1]);
        if (!hold_valid) begin
            @(negedge clk);
            check("done_one_cycle", {31'h0, done}, 32'h0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        seed_valid = 1'b0;
        seed       = 32'h0;
        rand_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seed_ready", {31'h0, seed_ready}, 32'h1);
        check("rst_rand_valid", {31'h0, rand_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_rand_num", rand_num, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Known first word for seed 1, then a full sequence at full rate.
        check("ref_first", ref_word(32'h1, 0), 32'h0004_2021);
        run_seq(32'h1, 100, 1'b0, 1'b0);

        // Zero seed follows the substitute seed.
        run_seq(32'h0, 100, 1'b0, 1'b0);

        // Random backpressure.
        run_seq(32'hDEAD_BEEF, 50, 1'b0, 1'b0);
        run_seq($urandom, 30, 1'b0, 1'b0);

        // seed_valid held through GEN: next seed taken right after done.
        run_seq(32'h1234_5678, 70, 1'b1, 1'b0);
        run_seq(32'h1234_5678, 100, 1'b0, 1'b0);

        // Reset in the middle of a sequence.
        seed       = 32'h1;
        seed_valid = 1'b1;
        rand_ready = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        repeat (100) @(negedge clk);
        check("mid_word100", rand_num, ref_word(32'h1, 100));
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        rand_ready = 1'b0;
        check("mid_rst_valid", {31'h0, rand_valid}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_seed_ready", {31'h0, seed_ready}, 32'h1);
        check("mid_rst_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("mid_rst_done2", {31'h0, done}, 32'h0);
        seed       = 32'h1;
        seed_valid = 1'b1;
        @(negedge clk);
        seed_valid = 1'b0;
        check("restart_first", rand_num, 32'h0004_2021);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Long stall on the last word.
        run_seq(32'hCAFE_F00D, 100, 1'b0, 1'b1);
        run_seq($urandom, 60, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_prgn_xorshift_core
`default_nettype wire
